// File: rtl/spi_rx_slave_if.sv
// rtl/spi_rx_slave_if.sv - received-frame handoff bus between the SPI receiver and its consumer
interface spi_rx_slave_if #(
  parameter int DATA_DEPTH = 54
);
  logic [DATA_DEPTH-1:0] rx_data;
  logic [7:0]            rx_bits;
  logic                  rx_valid;
  logic                  rx_ack;
  logic                  rx_ovf;

  modport master (output rx_data, rx_bits, rx_valid, rx_ovf, input rx_ack);
  modport slave  (input rx_data, rx_bits, rx_valid, rx_ovf, output rx_ack);
endinterface

// File: rtl/spi_rx_slave.sv
// rtl/spi_rx_slave.sv - SPI receive-only slave with latch-enable framing, timeout abort and one-deep frame hold
module spi_rx_slave #(
  parameter int DATA_DEPTH = 54,
  parameter int TIMEOUT    = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_sclk,
  input  logic           spi_mosi,
  input  logic           spi_le,
  spi_rx_slave_if.master rx,
  output logic           rx_overrun,
  output logic           frame_err
);

  localparam logic [7:0] DEPTH_CNT = 8'(DATA_DEPTH);
  localparam logic [7:0] TO_CNT    = 8'(TIMEOUT);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [2:0]            sclk_q, mosi_q, le_q;
  logic [DATA_DEPTH-1:0] shreg, sh_n;
  logic [7:0]            cnt, cnt_n, tcnt;
  logic                  ovf, ovf_n;
  logic                  sclk_rise, le_rise, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      mosi_q <= '0;
      le_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], spi_sclk};
      mosi_q <= {mosi_q[1:0], spi_mosi};
      le_q   <= {le_q[1:0], spi_le};
    end
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign le_rise   = le_q[1] & ~le_q[2];
  // A bit arriving with le in the same cycle belongs to the frame, even from IDLE.
  assign done      = le_rise && (state == SHIFT || sclk_rise);

  // mosi stage 3 lines up with the sclk edge seen between stages 2 and 3.
  always_comb begin
    sh_n  = shreg;
    cnt_n = cnt;
    ovf_n = ovf;
    if (sclk_rise) begin
      sh_n = {shreg[DATA_DEPTH-2:0], mosi_q[2]};
      if (cnt == DEPTH_CNT) ovf_n = 1'b1;
      else                  cnt_n = cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      tcnt        <= '0;
      ovf         <= 1'b0;
      rx.rx_data  <= '0;
      rx.rx_bits  <= '0;
      rx.rx_valid <= 1'b0;
      rx.rx_ovf   <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx.rx_valid && rx.rx_ack) rx.rx_valid <= 1'b0;

      if (done) begin
        if (!rx.rx_valid || rx.rx_ack) begin
          rx.rx_data  <= sh_n;
          rx.rx_bits  <= cnt_n;
          rx.rx_ovf   <= ovf_n;
          rx.rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
        shreg <= '0;
        cnt   <= '0;
        ovf   <= 1'b0;
        tcnt  <= '0;
        state <= IDLE;
      end else if (le_rise) begin
        frame_err <= 1'b1;
      end else if (sclk_rise) begin
        shreg <= sh_n;
        cnt   <= cnt_n;
        ovf   <= ovf_n;
        tcnt  <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        if (tcnt == TO_CNT) begin
          frame_err <= 1'b1;
          shreg     <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
          tcnt      <= '0;
          state     <= IDLE;
        end else begin
          tcnt <= tcnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_slave.sv
// tb/tb_spi_rx_slave.sv - self-checking bench for spi_rx_slave against a frame-level reference model
module tb_spi_rx_slave;
  localparam int D  = 54;
  localparam int TO = 255;

  logic clk = 1'b0, rst = 1'b1;
  logic spi_sclk = 1'b0, spi_mosi = 1'b0, spi_le = 1'b0;
  logic rx_overrun, frame_err;

  spi_rx_slave_if #(.DATA_DEPTH(D)) rx_if ();

  spi_rx_slave #(.DATA_DEPTH(D), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_le     (spi_le),
    .rx         (rx_if),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int err_seen = 0, exp_err = 0;
  bit fq[$];

  // reference model of what the consumer should be holding
  bit          m_valid, m_ovf, m_ovr;
  logic [63:0] m_data;
  int          m_bits;

  always @(negedge clk) if (frame_err) err_seen++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_val(input logic [63:0] v, input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(v[n-1-i]);
  endtask

  task automatic load_rand(input int n);
    fq.delete();
    for (int i = 0; i < n; i++) fq.push_back(bit'($urandom_range(0, 1)));
  endtask

  // the last D bits sent, last bit in position 0
  task automatic model_frame();
    int n = fq.size();
    logic [63:0] d = '0;
    if (n == 0) begin
      exp_err++;
      return;
    end
    for (int i = 0; i < n; i++) if (n - 1 - i < D) d[n-1-i] = fq[i];
    if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = d;
      m_bits  = (n > D) ? D : n;
      m_ovf   = (n > D);
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic send_frame(input bit coincide, input bit le_end);
    for (int i = 0; i < fq.size(); i++) begin
      spi_sclk = 1'b0;
      spi_mosi = fq[i];
      repeat (2) @(negedge clk);
      spi_sclk = 1'b1;
      if (le_end && coincide && i == fq.size() - 1) spi_le = 1'b1;
      repeat (3) @(negedge clk);
    end
    spi_sclk = 1'b0;
    if (le_end) begin
      if (!(coincide && fq.size() > 0)) begin
        repeat (2) @(negedge clk);
        spi_le = 1'b1;
        repeat (3) @(negedge clk);
      end
      spi_le = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
    if (m_valid) m_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_valid = 0; m_ovf = 0; m_ovr = 0; m_data = '0; m_bits = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 64'(rx_if.rx_valid), 64'(m_valid));
    if (m_valid) begin
      chk({tag, ".data"}, 64'(rx_if.rx_data), m_data);
      chk({tag, ".bits"}, 64'(rx_if.rx_bits), 64'(m_bits));
      chk({tag, ".ovf"},  64'(rx_if.rx_ovf),  64'(m_ovf));
    end
    chk({tag, ".overrun"}, 64'(rx_overrun), 64'(m_ovr));
    chk({tag, ".errs"},    64'(err_seen),   64'(exp_err));
  endtask

  initial begin
    rx_if.rx_ack = 1'b0;
    m_valid = 0; m_ovf = 0; m_ovr = 0; m_data = '0; m_bits = 0;
    repeat (3) @(negedge clk);
    chk("rst.valid",   64'(rx_if.rx_valid), 64'd0);
    chk("rst.data",    64'(rx_if.rx_data),  64'd0);
    chk("rst.bits",    64'(rx_if.rx_bits),  64'd0);
    chk("rst.ovf",     64'(rx_if.rx_ovf),   64'd0);
    chk("rst.overrun", 64'(rx_overrun),     64'd0);
    chk("rst.err",     64'(frame_err),      64'd0);
    rst = 1'b0;
    @(negedge clk);

    load_val(64'hA5C3F0, 24);
    send_frame(1'b0, 1'b1);
    model_frame();
    check_all("f24");
    chk("f24.const", 64'(rx_if.rx_data), 64'hA5C3F0);
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
    m_valid = 1'b0;
    chk("f24.ack", 64'(rx_if.rx_valid), 64'd0);

    load_rand(60);
    send_frame(1'b0, 1'b1);
    model_frame();
    check_all("f60");
    chk("f60.bits_const", 64'(rx_if.rx_bits), 64'd54);
    ack_pulse();

    load_rand(24);
    send_frame(1'b0, 1'b1);
    model_frame();
    load_val(64'h3, 2);
    send_frame(1'b0, 1'b1);
    model_frame();
    check_all("ovr");

    do_reset();
    load_rand(24);
    send_frame(1'b0, 1'b1);
    model_frame();
    load_val(64'h3, 2);
    send_frame(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    spi_le = 1'b1;
    repeat (2) @(negedge clk);
    rx_if.rx_ack = 1'b1;
    @(negedge clk);
    rx_if.rx_ack = 1'b0;
    spi_le = 1'b0;
    m_valid = 1'b0;
    model_frame();
    repeat (3) @(negedge clk);
    check_all("ackovl");
    chk("ackovl.const", 64'(rx_if.rx_data), 64'h3);
    ack_pulse();

    load_rand(10);
    send_frame(1'b0, 1'b0);
    repeat (300) @(negedge clk);
    exp_err++;
    check_all("tmo");
    fq.delete();
    send_frame(1'b0, 1'b1);
    model_frame();
    check_all("empty");

    load_rand(12);
    send_frame(1'b0, 1'b0);
    do_reset();
    repeat (2) @(negedge clk);
    check_all("midrst");
    chk("midrst.data", 64'(rx_if.rx_data), 64'd0);
    chk("midrst.bits", 64'(rx_if.rx_bits), 64'd0);
    load_val(64'h81, 8);
    send_frame(1'b0, 1'b1);
    model_frame();
    check_all("f81");
    chk("f81.const", 64'(rx_if.rx_data), 64'h81);
    ack_pulse();

    for (int it = 0; it < 12; it++) begin
      load_rand(int'($urandom_range(1, 62)));
      send_frame(bit'($urandom_range(0, 1)), 1'b1);
      model_frame();
      check_all($sformatf("rnd%0d", it));
      if ($urandom_range(0, 1) == 1) ack_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
